// File: rtl/uart_rx_autobaud_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_autobaud_ctrl_if
// Signal bundle between the autobaud calibration controller and its
// environment (serial line, calibration request, RX datapath configuration).
//
//   RX_IN      raw serial line into the controller
//   cal_start  one-cycle (re)calibration request
//   prescale   clk cycles per bit for the RX datapath
//   rx_en      RX datapath enable, high only while locked
//   cfg_valid  prescale holds a calibrated value
//   busy       calibration in progress
//   lock_err   calibration failed
//   err_code   failure cause: 01 saturation, 10 mismatch, 11 out of range
//
// master: the controller side; slave: the environment side.
// ---------------------------------------------------------------------------
interface uart_rx_autobaud_ctrl_if;
  logic       RX_IN;
  logic       cal_start;
  logic [4:0] prescale;
  logic       rx_en;
  logic       cfg_valid;
  logic       busy;
  logic       lock_err;
  logic [1:0] err_code;

  modport master (
    input  RX_IN,
    input  cal_start,
    output prescale,
    output rx_en,
    output cfg_valid,
    output busy,
    output lock_err,
    output err_code
  );

  modport slave (
    output RX_IN,
    output cal_start,
    input  prescale,
    input  rx_en,
    input  cfg_valid,
    input  busy,
    input  lock_err,
    input  err_code
  );
endinterface

// File: rtl/uart_rx_autobaud_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_autobaud_ctrl
// Measures a 0x55 sync character on the serial line and derives the
// oversampling prescale (clk cycles per bit). The five falling edges of
// 0x55 (start bit and data bits 1,3,5,7) bound four intervals of two bit
// periods each; their sum N spans eight bit periods, so prescale is N/8
// rounded to nearest. The RX datapath is enabled only once locked.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_rx_autobaud_ctrl_if.master (line in, request in, config out)
// ---------------------------------------------------------------------------
module uart_rx_autobaud_ctrl #(
  parameter int CNT_W            = 9,
  parameter int MIN_PRESCALE     = 4,
  parameter int MAX_PRESCALE     = 31,
  parameter int TOL              = 2,
  parameter int IDLE_CYC         = 16,
  parameter int DEFAULT_PRESCALE = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  uart_rx_autobaud_ctrl_if.master         bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam int               IDLE_W  = $clog2(IDLE_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_IDLE  = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_CHECK      = 3'd4,
    ST_LOCKED     = 3'd5,
    ST_ERR        = 3'd6
  } state_t;

  // Absolute difference of two interval values.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  // Registers
  state_t             state_r;
  logic               s1_r, s2_r, s3_r;
  logic [IDLE_W-1:0]  idle_cnt_r;
  logic [CNT_W-1:0]   int_cnt_r;
  logic [CNT_W-1:0]   sum_r;
  logic [CNT_W-1:0]   ref_r;
  logic [1:0]         edge_idx_r;
  logic [4:0]         prescale_r;
  logic               rx_en_r;
  logic               cfg_valid_r;
  logic               busy_r;
  logic               lock_err_r;
  logic [1:0]         err_code_r;

  // Next-state values
  state_t             state_s;
  logic [IDLE_W-1:0]  idle_cnt_s;
  logic [CNT_W-1:0]   int_cnt_s;
  logic [CNT_W-1:0]   sum_s;
  logic [CNT_W-1:0]   ref_s;
  logic [1:0]         edge_idx_s;
  logic [4:0]         prescale_s;
  logic [1:0]         err_code_s;

  // Datapath helpers
  logic               fall_s;
  logic [CNT_W-1:0]   interval_s;
  logic [CNT_W:0]     sum_ext_s;
  logic [CNT_W:0]     p_ext_s;

  // Only falling edges are ever measured; synchronizer delay is common to all.
  assign fall_s = s3_r & ~s2_r;

  // Counter is cleared on the fall that opens an interval, so the interval
  // in cycles is one more than the count seen on the closing fall. The
  // measurement branch is only taken when int_cnt_r < CNT_MAX, so no wrap.
  assign interval_s = int_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign sum_ext_s  = {1'b0, sum_r} + {1'b0, interval_s};
  // One spare bit keeps the +4 rounding term from wrapping near full scale.
  assign p_ext_s    = ({1'b0, sum_r} + (CNT_W+1)'(4)) >> 3;

  // Line synchronizer (s1, s2) plus history flop (s3); idle-high on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= bus.RX_IN;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_s    = state_r;
    idle_cnt_s = idle_cnt_r;
    int_cnt_s  = int_cnt_r;
    sum_s      = sum_r;
    ref_s      = ref_r;
    edge_idx_s = edge_idx_r;
    prescale_s = prescale_r;
    err_code_s = err_code_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.cal_start) begin
          state_s    = ST_WAIT_IDLE;
          idle_cnt_s = {IDLE_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (idle_cnt_r == IDLE_W'(IDLE_CYC)) begin
          state_s = ST_WAIT_START;
        end else if (s2_r) begin
          idle_cnt_s = idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
        end else begin
          idle_cnt_s = {IDLE_W{1'b0}};
        end
      end

      ST_WAIT_START: begin
        if (fall_s) begin
          int_cnt_s  = {CNT_W{1'b0}};
          sum_s      = {CNT_W{1'b0}};
          ref_s      = {CNT_W{1'b0}};
          edge_idx_s = 2'd0;
          state_s    = ST_MEASURE;
        end else begin
          state_s = ST_WAIT_START;
        end
      end

      ST_MEASURE: begin
        if (int_cnt_r == CNT_MAX) begin
          // Line stuck low or far too slow a baud rate.
          state_s    = ST_ERR;
          err_code_s = 2'b01;
        end else if (fall_s) begin
          int_cnt_s = {CNT_W{1'b0}};
          if (sum_ext_s >= {1'b0, CNT_MAX}) begin
            state_s    = ST_ERR;
            err_code_s = 2'b01;
          end else if ((edge_idx_r != 2'd0) &&
                       (abs_diff(interval_s, ref_r) > CNT_W'(TOL))) begin
            state_s    = ST_ERR;
            err_code_s = 2'b10;
          end else begin
            sum_s      = sum_ext_s[CNT_W-1:0];
            edge_idx_s = edge_idx_r + 2'd1;
            if (edge_idx_r == 2'd0) begin
              ref_s = interval_s;
            end else begin
              ref_s = ref_r;
            end
            if (edge_idx_r == 2'd3) begin
              state_s = ST_CHECK;
            end else begin
              state_s = ST_MEASURE;
            end
          end
        end else begin
          int_cnt_s = int_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_CHECK: begin
        if ((p_ext_s < (CNT_W+1)'(MIN_PRESCALE)) ||
            (p_ext_s > (CNT_W+1)'(MAX_PRESCALE))) begin
          state_s    = ST_ERR;
          err_code_s = 2'b11;
        end else begin
          prescale_s = p_ext_s[4:0];
          state_s    = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
        if (bus.cal_start) begin
          state_s    = ST_WAIT_IDLE;
          idle_cnt_s = {IDLE_W{1'b0}};
        end else begin
          state_s = ST_LOCKED;
        end
      end

      ST_ERR: begin
        if (bus.cal_start) begin
          state_s    = ST_WAIT_IDLE;
          idle_cnt_s = {IDLE_W{1'b0}};
          err_code_s = 2'b00;
        end else begin
          state_s = ST_ERR;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. Status outputs are decoded from
  // the next state so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idle_cnt_r  <= {IDLE_W{1'b0}};
      int_cnt_r   <= {CNT_W{1'b0}};
      sum_r       <= {CNT_W{1'b0}};
      ref_r       <= {CNT_W{1'b0}};
      edge_idx_r  <= 2'd0;
      prescale_r  <= 5'(DEFAULT_PRESCALE);
      rx_en_r     <= 1'b0;
      cfg_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      lock_err_r  <= 1'b0;
      err_code_r  <= 2'b00;
    end else begin
      state_r     <= state_s;
      idle_cnt_r  <= idle_cnt_s;
      int_cnt_r   <= int_cnt_s;
      sum_r       <= sum_s;
      ref_r       <= ref_s;
      edge_idx_r  <= edge_idx_s;
      prescale_r  <= prescale_s;
      rx_en_r     <= (state_s == ST_LOCKED);
      cfg_valid_r <= (state_s == ST_LOCKED);
      busy_r      <= (state_s == ST_WAIT_IDLE) || (state_s == ST_WAIT_START) ||
                     (state_s == ST_MEASURE)   || (state_s == ST_CHECK);
      lock_err_r  <= (state_s == ST_ERR);
      err_code_r  <= err_code_s;
    end
  end

  assign bus.prescale  = prescale_r;
  assign bus.rx_en     = rx_en_r;
  assign bus.cfg_valid = cfg_valid_r;
  assign bus.busy      = busy_r;
  assign bus.lock_err  = lock_err_r;
  assign bus.err_code  = err_code_r;

endmodule
